// File: rtl/pipeline_issue_scheduler_if.sv
// rtl/pipeline_issue_scheduler_if.sv - ID-stage / issue-control signal bundle for the issue scheduler
interface pipeline_issue_scheduler_if #(
  parameter int REG_AW   = 4,
  parameter int OPCODE_W = 3
);
  logic                id_valid;
  logic [OPCODE_W-1:0] id_opcode;
  logic [REG_AW-1:0]   id_rs1;
  logic [REG_AW-1:0]   id_rs2;
  logic                id_rs1_used;
  logic                id_rs2_used;
  logic [REG_AW-1:0]   id_rd;
  logic                id_wr;
  logic                ex_redirect;
  logic                mem_busy;
  logic                issue;
  logic                pc_we;
  logic                ifid_we;
  logic                idex_bubble;
  logic                ifid_flush;
  logic                stall;
  logic [15:0]         stall_cnt;

  // Pipeline side: presents the ID instruction and pipe status, consumes the controls
  modport master (
    output id_valid, id_opcode, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_wr, ex_redirect, mem_busy,
    input  issue, pc_we, ifid_we, idex_bubble, ifid_flush, stall, stall_cnt
  );

  // Scheduler side
  modport slave (
    input  id_valid, id_opcode, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_wr, ex_redirect, mem_busy,
    output issue, pc_we, ifid_we, idex_bubble, ifid_flush, stall, stall_cnt
  );
endinterface

// File: rtl/pipeline_issue_scheduler.sv
// rtl/pipeline_issue_scheduler.sv - scoreboard-based issue/stall/redirect controller for the 5-stage core
module pipeline_issue_scheduler #(
  parameter int                  REG_AW    = 4,
  parameter int                  OPCODE_W  = 3,
  parameter logic [OPCODE_W-1:0] JR_OPCODE = 3'b111,
  parameter int                  WB_LAT    = 3,
  parameter int                  R0_ZERO   = 1
) (
  input logic                      clk,
  input logic                      rst,
  pipeline_issue_scheduler_if.slave sif
);
  localparam int NREG = 1 << REG_AW;

  typedef enum logic {S_RUN = 1'b0, S_JR_WAIT = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q [NREG];
  logic [15:0] stall_cnt_q;

  logic rs1_busy, rs2_busy, raw, load_sb;
  logic issue_w, pc_we_w, ifid_we_w, bubble_w, flush_w, stall_w;

  // Hazard detect: a source is blocked while its producer's write is still in flight
  always_comb begin
    rs1_busy = sif.id_rs1_used && (cnt_q[sif.id_rs1] != 3'd0) &&
               !((R0_ZERO != 0) && (sif.id_rs1 == '0));
    rs2_busy = sif.id_rs2_used && (cnt_q[sif.id_rs2] != 3'd0) &&
               !((R0_ZERO != 0) && (sif.id_rs2 == '0));
    raw      = sif.id_valid && (rs1_busy || rs2_busy);
    load_sb  = issue_w && sif.id_wr && !((R0_ZERO != 0) && (sif.id_rd == '0));
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_RUN;
    else     state_q <= state_d;
  end

  // FSM next state: redirect always returns to RUN, an issued JR waits for its redirect
  always_comb begin
    state_d = state_q;
    if (!sif.mem_busy) begin
      if (sif.ex_redirect)                                state_d = S_RUN;
      else if (issue_w && (sif.id_opcode == JR_OPCODE))   state_d = S_JR_WAIT;
    end
  end

  // FSM outputs in priority order; reset forces the idle-fetch pattern
  always_comb begin
    issue_w   = 1'b0;
    pc_we_w   = 1'b1;
    ifid_we_w = 1'b1;
    bubble_w  = 1'b0;
    flush_w   = 1'b0;
    stall_w   = 1'b0;
    if (rst) begin
      issue_w = 1'b0;
    end else if (sif.mem_busy) begin
      pc_we_w   = 1'b0;
      ifid_we_w = 1'b0;
    end else if (sif.ex_redirect) begin
      flush_w  = 1'b1;
      bubble_w = 1'b1;
    end else if ((state_q == S_JR_WAIT) || raw) begin
      pc_we_w   = 1'b0;
      ifid_we_w = 1'b0;
      bubble_w  = 1'b1;
      stall_w   = 1'b1;
    end else if (sif.id_valid) begin
      issue_w = 1'b1;
    end else begin
      bubble_w = 1'b1;
    end
  end

  // Scoreboard: load on issuing a write, otherwise count down; whole table frozen on mem_busy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) cnt_q[i] <= 3'd0;
    end else if (!sif.mem_busy) begin
      for (int i = 0; i < NREG; i++) begin
        if (load_sb && (sif.id_rd == REG_AW'(i))) cnt_q[i] <= 3'(WB_LAT);
        else if (cnt_q[i] != 3'd0)                cnt_q[i] <= cnt_q[i] - 3'd1;
      end
    end
  end

  // Saturating count of hazard/JR stall cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                      stall_cnt_q <= 16'd0;
    else if (stall_w && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
  end

  assign sif.issue       = issue_w;
  assign sif.pc_we       = pc_we_w;
  assign sif.ifid_we     = ifid_we_w;
  assign sif.idex_bubble = bubble_w;
  assign sif.ifid_flush  = flush_w;
  assign sif.stall       = stall_w;
  assign sif.stall_cnt   = stall_cnt_q;
endmodule

// File: tb/tb_pipeline_issue_scheduler.sv
// tb/tb_pipeline_issue_scheduler.sv - directed scoreboard bench for pipeline_issue_scheduler
module tb_pipeline_issue_scheduler;
  // {issue, stall, pc_we, ifid_we, idex_bubble, ifid_flush}
  typedef logic [5:0] exp_t;
  localparam exp_t E_RST    = 6'b001100;
  localparam exp_t E_ISSUE  = 6'b101100;
  localparam exp_t E_STALL  = 6'b010010;
  localparam exp_t E_FREEZE = 6'b000000;
  localparam exp_t E_FLUSH  = 6'b001111;
  localparam exp_t E_IDLE   = 6'b001110;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  pipeline_issue_scheduler_if #(.REG_AW(4), .OPCODE_W(3)) sif ();

  pipeline_issue_scheduler #(
    .REG_AW(4), .OPCODE_W(3), .JR_OPCODE(3'b111), .WB_LAT(3), .R0_ZERO(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .sif (sif)
  );

  always #5 clk = ~clk;

  // Drive one cycle of stimulus at posedge+1, record the expected controls,
  // compare at the falling edge, then advance to the next posedge+1.
  task automatic step(input logic v, input logic [2:0] op,
                      input logic [3:0] rs1, input logic [3:0] rs2, input logic [3:0] rd,
                      input logic wr, input logic redir, input logic busy,
                      input exp_t e, input string tag);
    exp_t o, x;
    sif.id_valid    = v;
    sif.id_opcode   = op;
    sif.id_rs1      = rs1;
    sif.id_rs2      = rs2;
    sif.id_rs1_used = v;
    sif.id_rs2_used = v;
    sif.id_rd       = rd;
    sif.id_wr       = wr;
    sif.ex_redirect = redir;
    sif.mem_busy    = busy;
    exp_q.push_back(e);
    @(negedge clk);
    o = {sif.issue, sif.stall, sif.pc_we, sif.ifid_we, sif.idex_bubble, sif.ifid_flush};
    x = exp_q.pop_front();
    checks++;
    assert (o === x) else begin
      errors++;
      $error("FAIL %s ctrl observed=%b expected=%b", tag, o, x);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag, input logic [15:0] e);
    checks++;
    assert (sif.stall_cnt === e) else begin
      errors++;
      $error("FAIL %s stall_cnt observed=%0d expected=%0d", tag, sif.stall_cnt, e);
    end
  endtask

  initial begin
    rst = 1'b1;
    sif.id_valid = 1'b0; sif.id_opcode = '0; sif.id_rs1 = '0; sif.id_rs2 = '0;
    sif.id_rs1_used = 1'b0; sif.id_rs2_used = 1'b0; sif.id_rd = '0; sif.id_wr = 1'b0;
    sif.ex_redirect = 1'b0; sif.mem_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Outputs held at the reset pattern even with a valid ID instruction
    step(1, 3'd0, 4'd3, 4'd0, 4'd4, 1, 0, 0, E_RST, "reset_ctrl");
    chk_cnt("reset_cnt", 16'd0);
    rst = 1'b0;

    // Basic RAW: r3 writer then reader -> 3 stalls, issue on 4th
    step(1, 3'd0, 4'd1, 4'd0, 4'd3, 1, 0, 0, E_ISSUE, "raw_prod");
    step(1, 3'd0, 4'd3, 4'd0, 4'd4, 1, 0, 0, E_STALL, "raw_st1");
    step(1, 3'd0, 4'd3, 4'd0, 4'd4, 1, 0, 0, E_STALL, "raw_st2");
    step(1, 3'd0, 4'd3, 4'd0, 4'd4, 1, 0, 0, E_STALL, "raw_st3");
    step(1, 3'd0, 4'd3, 4'd0, 4'd4, 1, 0, 0, E_ISSUE, "raw_issue");
    chk_cnt("raw_cnt", 16'd3);
    for (int i = 0; i < 3; i++) step(0, 3'd0, 4'd0, 4'd0, 4'd0, 0, 0, 0, E_IDLE, "drain_nop");

    // RAW with a 2-cycle memory freeze mid-stall
    step(1, 3'd0, 4'd1, 4'd0, 4'd6, 1, 0, 0, E_ISSUE,  "busy_prod");
    step(1, 3'd0, 4'd6, 4'd0, 4'd0, 0, 0, 0, E_STALL,  "busy_st1");
    step(1, 3'd0, 4'd6, 4'd0, 4'd0, 0, 0, 1, E_FREEZE, "busy_frz1");
    step(1, 3'd0, 4'd6, 4'd0, 4'd0, 0, 0, 1, E_FREEZE, "busy_frz2");
    step(1, 3'd0, 4'd6, 4'd0, 4'd0, 0, 0, 0, E_STALL,  "busy_st2");
    step(1, 3'd0, 4'd6, 4'd0, 4'd0, 0, 0, 0, E_STALL,  "busy_st3");
    step(1, 3'd0, 4'd6, 4'd0, 4'd0, 0, 0, 0, E_ISSUE,  "busy_issue");
    chk_cnt("busy_cnt", 16'd6);

    // r0 never tracked: back-to-back issue
    step(1, 3'd0, 4'd1, 4'd0, 4'd0, 1, 0, 0, E_ISSUE, "r0_writer");
    step(1, 3'd0, 4'd0, 4'd0, 4'd1, 0, 0, 0, E_ISSUE, "r0_reader");
    chk_cnt("r0_cnt", 16'd6);

    // JR: wait with fetch frozen until the redirect pulse, then back to RUN
    step(1, 3'd7, 4'd1, 4'd0, 4'd0, 0, 0, 0, E_ISSUE, "jr_issue");
    step(1, 3'd0, 4'd1, 4'd0, 4'd0, 0, 0, 0, E_STALL, "jr_wait1");
    step(1, 3'd0, 4'd1, 4'd0, 4'd0, 0, 0, 0, E_STALL, "jr_wait2");
    step(1, 3'd0, 4'd1, 4'd0, 4'd0, 0, 1, 0, E_FLUSH, "jr_redirect");
    step(1, 3'd0, 4'd1, 4'd0, 4'd0, 0, 0, 0, E_ISSUE, "jr_run");
    chk_cnt("jr_cnt", 16'd8);

    // Redirect beats a RAW stall; flushed writer (r9) must not load the scoreboard
    step(1, 3'd0, 4'd1, 4'd0, 4'd2, 1, 0, 0, E_ISSUE, "rd_prod");
    step(1, 3'd0, 4'd2, 4'd0, 4'd9, 1, 1, 0, E_FLUSH, "rd_flush");
    step(1, 3'd0, 4'd9, 4'd0, 4'd0, 0, 0, 0, E_ISSUE, "rd_no_load");
    step(1, 3'd0, 4'd2, 4'd0, 4'd0, 0, 0, 0, E_STALL, "rd_st");
    step(1, 3'd0, 4'd2, 4'd0, 4'd0, 0, 0, 0, E_ISSUE, "rd_issue");
    chk_cnt("rd_cnt", 16'd9);

    // Reset in JR_WAIT with cnt[5]=2 clears everything
    step(1, 3'd0, 4'd1, 4'd0, 4'd5, 1, 0, 0, E_ISSUE, "rs_prod");
    step(1, 3'd7, 4'd1, 4'd0, 4'd0, 0, 0, 0, E_ISSUE, "rs_jr");
    rst = 1'b1;
    step(1, 3'd0, 4'd5, 4'd0, 4'd0, 0, 0, 0, E_RST, "rs_during");
    chk_cnt("rs_cnt", 16'd0);
    rst = 1'b0;
    step(1, 3'd0, 4'd5, 4'd0, 4'd0, 0, 0, 0, E_ISSUE, "rs_reader");
    chk_cnt("rs_cnt_after", 16'd0);

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL queue_empty observed=%0d expected=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
